// File: rtl/ex_wb_stage.sv
// Execute/writeback stage of the 3-stage RV32I pipeline: ALU, branch/jump
// resolution, and a ready-handshaked data-memory port with timeout.
module ex_wb_stage #(
  parameter logic [31:0] RESET       = 32'h0000_0000,
  parameter int          MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic        id_alu,
  input  logic        id_lui,
  input  logic        id_jal,
  input  logic        id_jalr,
  input  logic        id_branch,
  input  logic        id_mem_write,
  input  logic        id_mem_to_reg,
  input  logic        id_imm_sel,
  input  logic        id_subtype,
  input  logic [2:0]  id_func3,
  input  logic [4:0]  id_rd,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_imm,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        wb_stall,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        exception
);

  typedef enum logic [1:0] {IDLE = 2'd0, MEM = 2'd1, SQUASH = 2'd2} state_t;

  function automatic logic [31:0] alu_f(input logic [2:0] f3, input logic sub,
                                        input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'b000:  return sub ? a - b : a + b;
      3'b001:  return a << b[4:0];
      3'b010:  return {31'd0, $signed(a) < $signed(b)};
      3'b011:  return {31'd0, a < b};
      3'b100:  return a ^ b;
      3'b101:  return sub ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'b110:  return a | b;
      3'b111:  return a & b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic taken_f(input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] b);
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) < $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] load_ext_f(input logic [31:0] rdata, input logic [1:0] off,
                                             input logic [2:0] f3);
    logic [31:0] sh;
    sh = rdata >> {off, 3'b000};
    case (f3)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b100:  return {24'd0, sh[7:0]};
      3'b101:  return {16'd0, sh[15:0]};
      default: return rdata;
    endcase
  endfunction

  state_t      state_r, state_s;
  logic [15:0] cnt_r, cnt_s;
  logic [1:0]  ld_off_r, ld_off_s;
  logic [2:0]  ld_f3_r, ld_f3_s;
  logic [4:0]  ld_rd_r, ld_rd_s;
  logic        dmem_req_s, dmem_we_s, redirect_s, wb_we_s, exception_s;
  logic [31:0] dmem_addr_s, dmem_wdata_s, redirect_pc_s, wb_data_s;
  logic [3:0]  dmem_be_s;
  logic [4:0]  wb_rd_s;

  logic [31:0] op_b_s, ea_s, alu_s, target_s, result_s;
  logic        misalign_s;
  logic [3:0]  be_s;
  logic [31:0] lanes_s;

  assign op_b_s   = (id_imm_sel | id_mem_write) ? id_imm : rs2_data;
  assign ea_s     = rs1_data + id_imm;
  assign alu_s    = alu_f(id_func3, id_subtype, rs1_data, op_b_s);
  assign target_s = id_jalr ? {ea_s[31:1], 1'b0} : id_pc + id_imm;
  assign result_s = id_lui ? id_imm : ((id_jal | id_jalr) ? id_pc + 32'd4 : alu_s);
  assign wb_stall = (state_r == MEM);

  // Access size from funct3[1:0]: byte, half, otherwise word.
  always_comb begin
    misalign_s = 1'b0;
    be_s       = 4'b1111;
    lanes_s    = rs2_data;
    case (id_func3[1:0])
      2'b00: begin
        be_s    = 4'b0001 << ea_s[1:0];
        lanes_s = {4{rs2_data[7:0]}};
      end
      2'b01: begin
        misalign_s = ea_s[0];
        be_s       = ea_s[1] ? 4'b1100 : 4'b0011;
        lanes_s    = {2{rs2_data[15:0]}};
      end
      default: misalign_s = |ea_s[1:0];
    endcase
  end

  // Next-state and next-output logic; all outputs except wb_stall are registered.
  always_comb begin
    state_s       = state_r;
    cnt_s         = cnt_r;
    ld_off_s      = ld_off_r;
    ld_f3_s       = ld_f3_r;
    ld_rd_s       = ld_rd_r;
    dmem_req_s    = dmem_req;
    dmem_we_s     = dmem_we;
    dmem_addr_s   = dmem_addr;
    dmem_wdata_s  = dmem_wdata;
    dmem_be_s     = dmem_be;
    redirect_s    = 1'b0;
    redirect_pc_s = redirect_pc;
    wb_we_s       = 1'b0;
    wb_rd_s       = wb_rd;
    wb_data_s     = wb_data;
    exception_s   = exception;
    case (state_r)
      IDLE: begin
        if (!id_valid) begin
          state_s = IDLE;
        end else if (id_mem_write | id_mem_to_reg) begin
          if (misalign_s) begin
            exception_s = 1'b1;
          end else begin
            dmem_req_s   = 1'b1;
            dmem_we_s    = id_mem_write;
            dmem_addr_s  = {ea_s[31:2], 2'b00};
            dmem_be_s    = be_s;
            dmem_wdata_s = lanes_s;
            ld_off_s     = ea_s[1:0];
            ld_f3_s      = id_func3;
            ld_rd_s      = id_rd;
            cnt_s        = 16'd0;
            state_s      = MEM;
          end
        end else begin
          if (id_jal | id_jalr | (id_branch & taken_f(id_func3, rs1_data, rs2_data))) begin
            redirect_s    = 1'b1;
            redirect_pc_s = target_s;
            state_s       = SQUASH;
          end else begin
            state_s = IDLE;
          end
          if ((id_alu | id_lui | id_jal | id_jalr) && !id_branch && id_rd != 5'd0) begin
            wb_we_s   = 1'b1;
            wb_rd_s   = id_rd;
            wb_data_s = result_s;
          end else begin
            wb_we_s = 1'b0;
          end
        end
      end
      MEM: begin
        if (dmem_ready) begin
          dmem_req_s = 1'b0;
          dmem_we_s  = 1'b0;
          state_s    = IDLE;
          if (!dmem_we && ld_rd_r != 5'd0) begin
            wb_we_s   = 1'b1;
            wb_rd_s   = ld_rd_r;
            wb_data_s = load_ext_f(dmem_rdata, ld_off_r, ld_f3_r);
          end else begin
            wb_we_s = 1'b0;
          end
        end else if (cnt_r == 16'(MEM_TIMEOUT - 1)) begin
          dmem_req_s  = 1'b0;
          dmem_we_s   = 1'b0;
          exception_s = 1'b1;
          state_s     = IDLE;
        end else begin
          cnt_s = cnt_r + 16'd1;
        end
      end
      SQUASH: begin
        if (id_valid) begin
          state_s = IDLE;
        end else begin
          state_s = SQUASH;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      cnt_r       <= 16'd0;
      ld_off_r    <= 2'd0;
      ld_f3_r     <= 3'd0;
      ld_rd_r     <= 5'd0;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= 32'd0;
      dmem_wdata  <= 32'd0;
      dmem_be     <= 4'd0;
      redirect    <= 1'b0;
      redirect_pc <= RESET;
      wb_we       <= 1'b0;
      wb_rd       <= 5'd0;
      wb_data     <= 32'd0;
      exception   <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      ld_off_r    <= ld_off_s;
      ld_f3_r     <= ld_f3_s;
      ld_rd_r     <= ld_rd_s;
      dmem_req    <= dmem_req_s;
      dmem_we     <= dmem_we_s;
      dmem_addr   <= dmem_addr_s;
      dmem_wdata  <= dmem_wdata_s;
      dmem_be     <= dmem_be_s;
      redirect    <= redirect_s;
      redirect_pc <= redirect_pc_s;
      wb_we       <= wb_we_s;
      wb_rd       <= wb_rd_s;
      wb_data     <= wb_data_s;
      exception   <= exception_s;
    end
  end

endmodule
